// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions/interrupts, saves PC and cause,
// redirects fetch to the trap vector and returns to the saved PC on mret.
module trap_ctrl #(
    parameter int                MTVEC_W   = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] MTVEC_RST = ADDR_W'(16'h0100),
    parameter bit                VECTORED  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exception,
    input  logic              interrup,
    input  logic [31:0]       excep_info,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              mret,
    input  logic              csr_wr,
    input  logic              csr_sel,
    input  logic [ADDR_W-1:0] csr_wdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              stall,
    output logic [ADDR_W-1:0] mepc,
    output logic [31:0]       mcause,
    output logic              mie,
    output logic              in_trap,
    output logic              double_fault
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_JUMP    = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RET     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mepc_q, mepc_d;
    logic [ADDR_W-1:0] mtvec_q, mtvec_d;
    logic              irq_q, irq_d;
    logic [4:0]        cause_q, cause_d;
    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;
    logic              dfault_q, dfault_d;

    logic              take_exc_s;
    logic              take_irq_s;
    logic              accept_s;
    logic              unused_s;

    // An exception always wins; the interrupt must be held by its source until taken.
    assign take_exc_s = (state_q == ST_IDLE) && exception;
    assign take_irq_s = (state_q == ST_IDLE) && interrup && mie_q && !exception;
    assign accept_s   = take_exc_s || take_irq_s;
    assign unused_s   = ^{excep_info[31:5], csr_wdata[1]};

    // Next-state and CSR update logic
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mtvec_d  = mtvec_q;
        irq_d    = irq_q;
        cause_d  = cause_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        dfault_d = dfault_q;

        if (csr_wr) begin
            if (csr_sel) begin
                mie_d = csr_wdata[0];
            end else begin
                mtvec_d = {csr_wdata[ADDR_W-1:2], 2'b00};
            end
        end else begin
            mie_d = mie_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mepc_d  = take_exc_s ? pc : pc_next;
                    irq_d   = take_irq_s;
                    cause_d = excep_info[4:0];
                    state_d = ST_SAVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                // Hardware mask overrides any software write to mie on this edge.
                mpie_d  = mie_q;
                mie_d   = 1'b0;
                state_d = ST_JUMP;
            end
            ST_JUMP: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (exception) begin
                    dfault_d = 1'b1;
                end else if (mret) begin
                    state_d = ST_RET;
                end else begin
                    state_d = ST_HANDLER;
                end
            end
            ST_RET: begin
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and CSR registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mtvec_q  <= MTVEC_RST;
            irq_q    <= 1'b0;
            cause_q  <= 5'd0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            dfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mtvec_q  <= mtvec_d;
            irq_q    <= irq_d;
            cause_q  <= cause_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            dfault_q <= dfault_d;
        end
    end

    // Redirect, flush and stall outputs
    always_comb begin
        pc_load   = 1'b0;
        pc_target = '0;
        flush     = 1'b0;
        stall     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                flush = accept_s;
                stall = accept_s;
            end
            ST_SAVE: begin
                stall = 1'b1;
            end
            ST_JUMP: begin
                pc_load = 1'b1;
                stall   = 1'b1;
                if (irq_q && VECTORED) begin
                    pc_target = mtvec_q + ADDR_W'({cause_q, 2'b00});
                end else begin
                    pc_target = mtvec_q;
                end
            end
            ST_RET: begin
                pc_load   = 1'b1;
                pc_target = mepc_q;
                flush     = 1'b1;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    assign mepc         = mepc_q;
    assign mcause       = {irq_q, 26'd0, cause_q};
    assign mie          = mie_q;
    assign in_trap      = (state_q != ST_IDLE);
    assign double_fault = dfault_q;

endmodule
